demultiplexor_tdm: RTL and testbench

- Receive end of the 4:1 time-multiplexed 4-bit link: takes the shared 4-bit data bus and steers each word into one of four registered channel outputs.
- Two modes.
  - Addressed: the channel comes from the select lines.
  - Auto-scan: an internal slot counter, aligned by a sync marker, picks the channel.
- Also packs each completed set of four channel words into a 16-bit frame with a one-cycle valid strobe.

---
 rtl/demultiplexor_tdm_pkg.sv | 26 ++
 rtl/demultiplexor_tdm_contador_slot.sv | 33 +++
 rtl/demultiplexor_tdm.sv | 170 +++++++++++++++++
 tb/tb_demultiplexor_tdm.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/demultiplexor_tdm_pkg.sv
// Shared definitions for the receive end of the 4:1 TDM link.
// Holds the link dimensions, the mode encodings, the receive FSM state
// type and a small select-to-one-hot helper used by the write decoder.
package demultiplexor_tdm_pkg;

  localparam int DATA_W  = 4;
  localparam int N_CH    = 4;
  localparam int SEL_W   = 2;
  localparam int TRAMA_W = 16;

  localparam logic MODO_DIREC = 1'b0;
  localparam logic MODO_AUTO  = 1'b1;

  typedef enum logic {
    ESPERA = 1'b0,
    RECIBE = 1'b1
  } estado_t;

  function automatic logic [N_CH-1:0] one_hot(input logic [SEL_W-1:0] idx);
    logic [N_CH-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/demultiplexor_tdm_contador_slot.sv
// 2-bit wrapping slot counter for auto-scan reception.
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset (count -> 0)
//   clr      synchronous clear to 0
//   load_uno synchronous load of 1 (slot 0 has just been received)
//   en       advance by one, wrapping 3 -> 0
//   cuenta   current count
// Priority: rst_n, clr, load_uno, en.
module contador_slot
  import demultiplexor_tdm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load_uno,
  input  logic             en,
  output logic [SEL_W-1:0] cuenta
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cuenta <= '0;
    end else if (clr) begin
      cuenta <= '0;
    end else if (load_uno) begin
      cuenta <= SEL_W'(1);
    end else if (en) begin
      cuenta <= cuenta + SEL_W'(1);
    end
  end

endmodule

// File: rtl/demultiplexor_tdm.sv
// Receive end of the 4:1 time-multiplexed 4-bit link.
// Steers each valid word on the shared bus into one of four registered
// channel outputs, either by the select lines (addressed mode) or by a
// sync-aligned slot counter (auto-scan mode), and packs every completed
// set of four channel words into a 16-bit frame.
// Ports:
//   i_Clk, i_Rst_n         clock and synchronous active-low reset
//   i_Dato, i_Valido       shared data word and its qualifier
//   i_Sel                  channel index (addressed mode)
//   i_Modo                 0 = addressed, 1 = auto-scan
//   i_Sync                 marks the current word as slot 0 (auto-scan)
//   o_Canal_1..o_Canal_4   registered channel words
//   o_Act                  one-hot strobe of the channel written this cycle
//   o_Slot                 next expected slot in auto-scan
//   o_Trama, o_Trama_Valida  packed frame {c4,c3,c2,c1} and its pulse
//   o_Error                pulse on overrun (addressed) or resync (auto)
module demultiplexor_tdm
  import demultiplexor_tdm_pkg::*;
(
  input  logic               i_Clk,
  input  logic               i_Rst_n,
  input  logic [DATA_W-1:0]  i_Dato,
  input  logic               i_Valido,
  input  logic [SEL_W-1:0]   i_Sel,
  input  logic               i_Modo,
  input  logic               i_Sync,
  output logic [DATA_W-1:0]  o_Canal_1,
  output logic [DATA_W-1:0]  o_Canal_2,
  output logic [DATA_W-1:0]  o_Canal_3,
  output logic [DATA_W-1:0]  o_Canal_4,
  output logic [N_CH-1:0]    o_Act,
  output logic [SEL_W-1:0]   o_Slot,
  output logic [TRAMA_W-1:0] o_Trama,
  output logic               o_Trama_Valida,
  output logic               o_Error
);

  estado_t estado_q, estado_d;

  // Packed so that the whole array is directly the frame layout:
  // channel 0 (canal 1) lands in the low nibble.
  logic [N_CH-1:0][DATA_W-1:0] canal_q, canal_d;
  logic [N_CH-1:0]             act_q, act_d;
  logic [N_CH-1:0]             mask_q, mask_d;
  logic [TRAMA_W-1:0]          trama_q, trama_d;
  logic                        trama_valida_q, trama_valida_d;
  logic                        error_q, error_d;
  logic                        modo_q, modo_d;

  logic [SEL_W-1:0] slot;
  logic             slot_clr, slot_load, slot_inc;

  contador_slot u_contador_slot (
    .clk      (i_Clk),
    .rst_n    (i_Rst_n),
    .clr      (slot_clr),
    .load_uno (slot_load),
    .en       (slot_inc),
    .cuenta   (slot)
  );

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      estado_q <= ESPERA;
    end else begin
      estado_q <= estado_d;
    end
  end

  // A mode change is a flush cycle: the word on the bus is dropped and
  // reception restarts from scratch, but already received channel and
  // frame values are preserved.
  always_comb begin
    estado_d       = estado_q;
    canal_d        = canal_q;
    act_d          = '0;
    mask_d         = mask_q;
    trama_d        = trama_q;
    trama_valida_d = 1'b0;
    error_d        = 1'b0;
    modo_d         = modo_q;
    slot_clr       = 1'b0;
    slot_load      = 1'b0;
    slot_inc       = 1'b0;

    if (i_Modo != modo_q) begin
      modo_d   = i_Modo;
      slot_clr = 1'b1;
      mask_d   = '0;
      estado_d = ESPERA;
    end else if (modo_q == MODO_DIREC) begin
      estado_d = ESPERA;
      if (i_Valido) begin
        canal_d[i_Sel] = i_Dato;
        act_d          = one_hot(i_Sel);
        // Writing a channel twice before the frame completes is an
        // overrun; the newer word still wins.
        error_d        = mask_q[i_Sel];
        if ((mask_q | act_d) == '1) begin
          trama_d        = canal_d;
          trama_valida_d = 1'b1;
          mask_d         = '0;
        end else begin
          mask_d = mask_q | act_d;
        end
      end
    end else if (i_Valido) begin
      case (estado_q)
        ESPERA: begin
          if (i_Sync) begin
            canal_d[0] = i_Dato;
            act_d      = one_hot(SEL_W'(0));
            slot_load  = 1'b1;
            estado_d   = RECIBE;
          end
        end
        RECIBE: begin
          if (i_Sync) begin
            // Sync anywhere but slot 0 realigns; the partial frame never
            // reaches slot 3, so it is never packed.
            error_d    = (slot != SEL_W'(0));
            canal_d[0] = i_Dato;
            act_d      = one_hot(SEL_W'(0));
            slot_load  = 1'b1;
          end else begin
            canal_d[slot] = i_Dato;
            act_d         = one_hot(slot);
            slot_inc      = 1'b1;
            if (slot == SEL_W'(N_CH - 1)) begin
              trama_d        = canal_d;
              trama_valida_d = 1'b1;
            end
          end
        end
        default: estado_d = ESPERA;
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      canal_q        <= '0;
      act_q          <= '0;
      mask_q         <= '0;
      trama_q        <= '0;
      trama_valida_q <= 1'b0;
      error_q        <= 1'b0;
      modo_q         <= MODO_DIREC;
    end else begin
      canal_q        <= canal_d;
      act_q          <= act_d;
      mask_q         <= mask_d;
      trama_q        <= trama_d;
      trama_valida_q <= trama_valida_d;
      error_q        <= error_d;
      modo_q         <= modo_d;
    end
  end

  assign o_Canal_1      = canal_q[0];
  assign o_Canal_2      = canal_q[1];
  assign o_Canal_3      = canal_q[2];
  assign o_Canal_4      = canal_q[3];
  assign o_Act          = act_q;
  assign o_Slot         = slot;
  assign o_Trama        = trama_q;
  assign o_Trama_Valida = trama_valida_q;
  assign o_Error        = error_q;

endmodule

// File: tb/tb_demultiplexor_tdm.sv
// Directed scoreboard bench for demultiplexor_tdm. Each step drives one
// cycle of inputs and queues the outputs expected after the next rising
// edge; the queued entry is popped and compared field by field.
module tb_demultiplexor_tdm;

  typedef struct packed {
    logic [15:0] canal;
    logic [3:0]  act;
    logic [1:0]  slot;
    logic [15:0] trama;
    logic        tv;
    logic        err;
  } exp_t;

  logic        i_Clk = 1'b0;
  logic        i_Rst_n;
  logic [3:0]  i_Dato;
  logic        i_Valido;
  logic [1:0]  i_Sel;
  logic        i_Modo;
  logic        i_Sync;
  logic [3:0]  o_Canal_1, o_Canal_2, o_Canal_3, o_Canal_4;
  logic [3:0]  o_Act;
  logic [1:0]  o_Slot;
  logic [15:0] o_Trama;
  logic        o_Trama_Valida;
  logic        o_Error;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  demultiplexor_tdm dut (
    .i_Clk          (i_Clk),
    .i_Rst_n        (i_Rst_n),
    .i_Dato         (i_Dato),
    .i_Valido       (i_Valido),
    .i_Sel          (i_Sel),
    .i_Modo         (i_Modo),
    .i_Sync         (i_Sync),
    .o_Canal_1      (o_Canal_1),
    .o_Canal_2      (o_Canal_2),
    .o_Canal_3      (o_Canal_3),
    .o_Canal_4      (o_Canal_4),
    .o_Act          (o_Act),
    .o_Slot         (o_Slot),
    .o_Trama        (o_Trama),
    .o_Trama_Valida (o_Trama_Valida),
    .o_Error        (o_Error)
  );

  always #5 i_Clk = ~i_Clk;

  function automatic exp_t mk(input logic [15:0] canal, input logic [3:0] act,
                              input logic [1:0] slot, input logic [15:0] trama,
                              input logic tv, input logic err);
    exp_t e;
    e.canal = canal;
    e.act   = act;
    e.slot  = slot;
    e.trama = trama;
    e.tv    = tv;
    e.err   = err;
    return e;
  endfunction

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    checks++;
    assert (sb_q.size() != 0)
    else begin
      errors++;
      $error("[TB] FAIL %s scoreboard empty observed 0 expected 1", tag);
      return;
    end
    e = sb_q.pop_front();
    check({tag, ".canal"}, {o_Canal_4, o_Canal_3, o_Canal_2, o_Canal_1}, e.canal);
    check({tag, ".act"},   {12'h0, o_Act}, {12'h0, e.act});
    check({tag, ".slot"},  {14'h0, o_Slot}, {14'h0, e.slot});
    check({tag, ".trama"}, o_Trama, e.trama);
    check({tag, ".tv"},    {15'h0, o_Trama_Valida}, {15'h0, e.tv});
    check({tag, ".err"},   {15'h0, o_Error}, {15'h0, e.err});
  endtask

  task automatic applyStimulus(input string tag, input logic rst_n, input logic modo,
                               input logic valido, input logic sync,
                               input logic [1:0] sel, input logic [3:0] dato,
                               input exp_t e);
    @(negedge i_Clk);
    i_Rst_n  = rst_n;
    i_Modo   = modo;
    i_Valido = valido;
    i_Sync   = sync;
    i_Sel    = sel;
    i_Dato   = dato;
    sb_q.push_back(e);
    @(posedge i_Clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    i_Rst_n = 1'b0; i_Modo = 1'b0; i_Valido = 1'b0; i_Sync = 1'b0; i_Sel = 2'd0; i_Dato = 4'h0;

    // Reset state
    applyStimulus("rst",      0, 0, 0, 0, 0, 4'h0, mk(16'h0000, 4'b0000, 0, 16'h0000, 0, 0));

    // Reset mid-frame
    applyStimulus("rm.flush", 1, 1, 1, 1, 0, 4'h1, mk(16'h0000, 4'b0000, 0, 16'h0000, 0, 0));
    applyStimulus("rm.s0",    1, 1, 1, 1, 0, 4'h1, mk(16'h0001, 4'b0001, 1, 16'h0000, 0, 0));
    applyStimulus("rm.s1",    1, 1, 1, 0, 0, 4'h2, mk(16'h0021, 4'b0010, 2, 16'h0000, 0, 0));
    applyStimulus("rm.rst",   0, 1, 1, 0, 0, 4'h3, mk(16'h0000, 4'b0000, 0, 16'h0000, 0, 0));
    applyStimulus("rm.flush2",1, 1, 1, 0, 0, 4'h5, mk(16'h0000, 4'b0000, 0, 16'h0000, 0, 0));
    applyStimulus("rm.disc",  1, 1, 1, 0, 0, 4'h5, mk(16'h0000, 4'b0000, 0, 16'h0000, 0, 0));

    // Auto frame
    applyStimulus("af.s0",    1, 1, 1, 1, 3, 4'h1, mk(16'h0001, 4'b0001, 1, 16'h0000, 0, 0));
    applyStimulus("af.s1",    1, 1, 1, 0, 3, 4'h2, mk(16'h0021, 4'b0010, 2, 16'h0000, 0, 0));
    applyStimulus("af.s2",    1, 1, 1, 0, 0, 4'h3, mk(16'h0321, 4'b0100, 3, 16'h0000, 0, 0));
    applyStimulus("af.s3",    1, 1, 1, 0, 1, 4'h4, mk(16'h4321, 4'b1000, 0, 16'h4321, 1, 0));
    applyStimulus("af.idle",  1, 1, 0, 0, 0, 4'h9, mk(16'h4321, 4'b0000, 0, 16'h4321, 0, 0));

    // Resync
    applyStimulus("rs.a",     1, 1, 1, 1, 0, 4'hA, mk(16'h432A, 4'b0001, 1, 16'h4321, 0, 0));
    applyStimulus("rs.b",     1, 1, 1, 0, 0, 4'hB, mk(16'h43BA, 4'b0010, 2, 16'h4321, 0, 0));
    applyStimulus("rs.c",     1, 1, 1, 1, 0, 4'hC, mk(16'h43BC, 4'b0001, 1, 16'h4321, 0, 1));
    applyStimulus("rs.d",     1, 1, 1, 0, 0, 4'hD, mk(16'h43DC, 4'b0010, 2, 16'h4321, 0, 0));
    applyStimulus("rs.e",     1, 1, 1, 0, 0, 4'hE, mk(16'h4EDC, 4'b0100, 3, 16'h4321, 0, 0));
    applyStimulus("rs.f",     1, 1, 1, 0, 0, 4'hF, mk(16'hFEDC, 4'b1000, 0, 16'hFEDC, 1, 0));

    // Addressed with overrun
    applyStimulus("ad.flush", 1, 0, 1, 0, 2, 4'h7, mk(16'hFEDC, 4'b0000, 0, 16'hFEDC, 0, 0));
    applyStimulus("ad.w27",   1, 0, 1, 0, 2, 4'h7, mk(16'hF7DC, 4'b0100, 0, 16'hFEDC, 0, 0));
    applyStimulus("ad.w28",   1, 0, 1, 1, 2, 4'h8, mk(16'hF8DC, 4'b0100, 0, 16'hFEDC, 0, 1));
    applyStimulus("ad.w01",   1, 0, 1, 0, 0, 4'h1, mk(16'hF8D1, 4'b0001, 0, 16'hFEDC, 0, 0));
    applyStimulus("ad.w39",   1, 0, 1, 0, 3, 4'h9, mk(16'h98D1, 4'b1000, 0, 16'hFEDC, 0, 0));
    applyStimulus("ad.w15",   1, 0, 1, 0, 1, 4'h5, mk(16'h9851, 4'b0010, 0, 16'h9851, 1, 0));

    // Mode switch flush
    applyStimulus("ms.w03",   1, 0, 1, 0, 0, 4'h3, mk(16'h9853, 4'b0001, 0, 16'h9851, 0, 0));
    applyStimulus("ms.w14",   1, 0, 1, 0, 1, 4'h4, mk(16'h9843, 4'b0010, 0, 16'h9851, 0, 0));
    applyStimulus("ms.flush", 1, 1, 1, 0, 2, 4'h6, mk(16'h9843, 4'b0000, 0, 16'h9851, 0, 0));
    applyStimulus("ms.disc",  1, 1, 1, 0, 2, 4'h7, mk(16'h9843, 4'b0000, 0, 16'h9851, 0, 0));

    // Idle gaps, including a sync that arrives without valid
    applyStimulus("ig.s0",    1, 1, 1, 1, 0, 4'h1, mk(16'h9841, 4'b0001, 1, 16'h9851, 0, 0));
    applyStimulus("ig.gap0",  1, 1, 0, 1, 0, 4'hE, mk(16'h9841, 4'b0000, 1, 16'h9851, 0, 0));
    applyStimulus("ig.s1",    1, 1, 1, 0, 0, 4'h2, mk(16'h9821, 4'b0010, 2, 16'h9851, 0, 0));
    applyStimulus("ig.gap1",  1, 1, 0, 0, 0, 4'h0, mk(16'h9821, 4'b0000, 2, 16'h9851, 0, 0));
    applyStimulus("ig.s2",    1, 1, 1, 0, 0, 4'h3, mk(16'h9321, 4'b0100, 3, 16'h9851, 0, 0));
    applyStimulus("ig.gap2",  1, 1, 0, 0, 0, 4'h0, mk(16'h9321, 4'b0000, 3, 16'h9851, 0, 0));
    applyStimulus("ig.s3",    1, 1, 1, 0, 0, 4'h4, mk(16'h4321, 4'b1000, 0, 16'h4321, 1, 0));
    applyStimulus("ig.after", 1, 1, 0, 0, 0, 4'h0, mk(16'h4321, 4'b0000, 0, 16'h4321, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
